blake2_cmd_tx: RTL
==================

Name: blake2_cmd_tx

Overview:
- Host-side transmitter for the BLAKE2 byte command stream (valid/cmd/data).
- On a start pulse it emits a 10-byte configuration burst: kk, nn, then ll as 8 bytes MSB first.
- It then streams key and message bytes pulled from a byte source, zero-padding each partial block to 64 bytes.
- It tags each block with START/LAST/DATA commands, so the hash core receives complete 64-byte blocks.

Parameters:
- CMD_CONF, 2'd0, configuration byte command code.
- CMD_START, 2'd1, first byte of first block.
- CMD_DATA, 2'd2, ordinary data byte.
- CMD_LAST, 2'd3, first byte of final block.

Ports:
- clk  in  1  clock.
- nreset  in  1  asynchronous active-low reset.
- start_i  in  1  pulse; latch kk_i/nn_i/ll_i and begin a message; ignored while busy_o=1.
- kk_i  in  8  key length in bytes (0..64).
- nn_i  in  8  digest length in bytes, passed through in config only.
- ll_i  in  64  message length in bytes.
- src_valid_i  in  1  source byte available.
- src_data_i  in  8  source byte; carries the kk key bytes first, then the ll message bytes.
- src_ready_o  out  1  byte consumed this cycle (src_valid_i & src_ready_o).
- valid_o  out  1  command byte valid (registered).
- cmd_o  out  2  command code (registered).
- data_o  out  8  byte payload (registered).
- busy_o  out  1  message in progress.
- done_o  out  1  one-cycle pulse after the last byte of the final block is emitted.

Behaviour:
- Clock and reset: one clock `clk`; reset `nreset` is asynchronous, active-low.
- Reset values: valid_o=0, cmd_o=0, data_o=0, src_ready_o=0, busy_o=0, done_o=0, FSM=IDLE, all counters 0.
- Reset mid-message aborts immediately. No partial stream resumes; the next start_i begins fresh.
- Block count: key blocks KB = (kk>0); message blocks MB = ceil(ll/64). Total TB = KB+MB, forced to 1 when KB+MB = 0.
- Counters are remaining-byte downcounters (64-bit for message, 7-bit for key). No multiplication.

FSM:
- IDLE: start_i latches the config, busy_o<=1. Go to WAITSRC if kk+ll>0, else CONF.
- WAITSRC: hold until src_valid_i=1 (guarantees the first data byte follows the config with no gap), then CONF.
  - Source readiness is not otherwise checked until DATA.
- CONF: emit 10 consecutive cycles, valid_o=1, cmd_o=CMD_CONF. Bytes are kk, nn, ll[63:56] .. ll[7:0]. Gap-free; cfg index 0..9; then DATA.
- DATA: the next cycle after CONF must carry the first data byte (valid_o=1).
  - While key or message bytes remain, src_ready_o=1.
  - A byte is emitted in the cycle after each handshake.
  - src_valid_i=0 gives valid_o=0 (stall). The byte index does not advance.
  - When the key bytes are exhausted mid-block, or the message bytes are exhausted mid-block, go to PAD.
  - The key block always pads to 64 before message bytes start.
- PAD: emit data 8'h00 with valid_o=1 every cycle, no source handshake, until byte index wraps 63->0.
  - Then go to DATA if bytes remain, else DONE.
- Zero-length case (kk=0, ll=0): after CONF, go straight to PAD and emit 64 zero bytes.
- DONE: done_o=1 for one cycle, busy_o<=0, return to IDLE. start_i in the DONE cycle is ignored.

Command tagging (per emitted data/pad byte):
- Byte index 0 of block 0 with TB>1: CMD_START.
- Byte index 0 of block TB-1: CMD_LAST. This also covers TB=1 (single block is tagged LAST only).
- All other bytes: CMD_DATA.

Further rules:
- Byte index is 6 bits and wraps naturally at 64. Every message emits exactly 64*TB data bytes.
- Latency from start_i to the first CONF byte:
  - 1 cycle if src_valid_i=1 or kk+ll=0;
  - otherwise 1 cycle after src_valid_i rises.
- src_ready_o is 0 outside DATA and in PAD. It never accepts more than kk+ll bytes per message.

Test Plan:
- kk=0, nn=32, ll=3, source AA BB CC always valid -> CONF 00 20 00 00 00 00 00 00 00 03; then LAST:AA, DATA:BB, DATA:CC, 61x DATA:00; done_o at cycle 1+10+64.
- kk=0, ll=0 -> 10 CONF bytes, then LAST:00 plus 63x DATA:00; src_ready_o never 1; one done_o pulse.
- kk=2, ll=64, key 11 22, message 00..3F -> START:11, DATA:22, 62x DATA:00; then LAST:00, DATA:01..3F; exactly 66 handshakes.
- kk=0, ll=130 with src_valid_i low 3 cycles at byte 70 -> START at byte 0, DATA elsewhere; 3 idle valid_o=0 cycles; LAST at byte 128, then 62 pad zeros; total 192 data bytes.
- start_i pulsed while busy, and during DONE -> ignored, no second config burst; after IDLE a new start_i restarts normally.
- nreset asserted at byte 40 of block 1 -> all outputs 0 asynchronously; next start_i emits a fresh, full config burst.

Source files
------------

// File: rtl/blake2_cmd_tx.sv
// Host-side BLAKE2 command-stream transmitter: a 10-byte config burst, then key and
// message bytes zero-padded into tagged 64-byte blocks.
module blake2_cmd_tx #(
  parameter logic [1:0] CMD_CONF  = 2'd0,
  parameter logic [1:0] CMD_START = 2'd1,
  parameter logic [1:0] CMD_DATA  = 2'd2,
  parameter logic [1:0] CMD_LAST  = 2'd3
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        start_i,
  input  logic [7:0]  kk_i,
  input  logic [7:0]  nn_i,
  input  logic [63:0] ll_i,
  input  logic        src_valid_i,
  input  logic [7:0]  src_data_i,
  output logic        src_ready_o,
  output logic        valid_o,
  output logic [1:0]  cmd_o,
  output logic [7:0]  data_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam int unsigned LEN_W    = 64;
  localparam int unsigned KEY_W    = 7;
  localparam int unsigned IDX_W    = 6;
  localparam int unsigned CFG_W    = 4;
  localparam int unsigned CFG_LAST = 9;
  localparam int unsigned BLK_LEN  = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAITSRC,
    S_CONF,
    S_DATA,
    S_PAD,
    S_DONE
  } state_t;

  state_t             state;
  logic [7:0]         kk_q;
  logic [7:0]         nn_q;
  logic [LEN_W-1:0]   ll_q;
  logic [KEY_W-1:0]   key_rem;
  logic [LEN_W-1:0]   msg_rem;
  logic [IDX_W-1:0]   byte_idx;
  logic [CFG_W-1:0]   cfg_idx;
  logic               first_blk;

  logic               key_phase_c;
  logic               rem_c;
  logic               last_blk_c;
  logic               seg_end_c;
  logic               more_c;
  logic               blk_end_c;
  logic               hs_c;
  logic [1:0]         tag_c;
  logic [7:0]         conf_byte_c;

  // The final block is the one that absorbs every remaining byte, so LAST needs no block count.
  always_comb begin
    key_phase_c = (key_rem != '0);
    rem_c       = key_phase_c || (msg_rem != '0);
    last_blk_c  = key_phase_c ? (msg_rem == '0) : (msg_rem <= LEN_W'(BLK_LEN));
    seg_end_c   = key_phase_c ? (key_rem == KEY_W'(1)) : (msg_rem == LEN_W'(1));
    more_c      = key_phase_c && (msg_rem != '0);
    blk_end_c   = (byte_idx == '1);
    hs_c        = src_valid_i && src_ready_o;
    tag_c       = CMD_DATA;
    if (byte_idx == '0) begin
      if (last_blk_c) begin
        tag_c = CMD_LAST;
      end else if (first_blk) begin
        tag_c = CMD_START;
      end
    end
  end

  // Config burst byte order: kk, nn, then ll MSB first.
  always_comb begin
    conf_byte_c = 8'h00;
    case (cfg_idx)
      CFG_W'(0): conf_byte_c = kk_q;
      CFG_W'(1): conf_byte_c = nn_q;
      CFG_W'(2): conf_byte_c = ll_q[63:56];
      CFG_W'(3): conf_byte_c = ll_q[55:48];
      CFG_W'(4): conf_byte_c = ll_q[47:40];
      CFG_W'(5): conf_byte_c = ll_q[39:32];
      CFG_W'(6): conf_byte_c = ll_q[31:24];
      CFG_W'(7): conf_byte_c = ll_q[23:16];
      CFG_W'(8): conf_byte_c = ll_q[15:8];
      CFG_W'(9): conf_byte_c = ll_q[7:0];
      default:   conf_byte_c = 8'h00;
    endcase
  end

  // State names the action taken at the next edge, so the first config byte
  // appears the cycle after start and data follows config without a gap.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state       <= S_IDLE;
      kk_q        <= '0;
      nn_q        <= '0;
      ll_q        <= '0;
      key_rem     <= '0;
      msg_rem     <= '0;
      byte_idx    <= '0;
      cfg_idx     <= '0;
      first_blk   <= 1'b0;
      src_ready_o <= 1'b0;
      valid_o     <= 1'b0;
      cmd_o       <= '0;
      data_o      <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      done_o  <= 1'b0;
      case (state)
        S_IDLE: begin
          // done_o high means the DONE cycle just ended; a start there is dropped.
          if (start_i && !done_o) begin
            kk_q      <= kk_i;
            nn_q      <= nn_i;
            ll_q      <= ll_i;
            key_rem   <= KEY_W'(kk_i);
            msg_rem   <= ll_i;
            byte_idx  <= '0;
            first_blk <= 1'b1;
            busy_o    <= 1'b1;
            if (src_valid_i || ((kk_i == '0) && (ll_i == '0))) begin
              valid_o <= 1'b1;
              cmd_o   <= CMD_CONF;
              data_o  <= kk_i;
              cfg_idx <= CFG_W'(1);
              state   <= S_CONF;
            end else begin
              state <= S_WAITSRC;
            end
          end
        end
        S_WAITSRC: begin
          if (src_valid_i) begin
            valid_o <= 1'b1;
            cmd_o   <= CMD_CONF;
            data_o  <= kk_q;
            cfg_idx <= CFG_W'(1);
            state   <= S_CONF;
          end
        end
        S_CONF: begin
          valid_o <= 1'b1;
          cmd_o   <= CMD_CONF;
          data_o  <= conf_byte_c;
          if (cfg_idx == CFG_W'(CFG_LAST)) begin
            cfg_idx <= '0;
            if (rem_c) begin
              src_ready_o <= 1'b1;
              state       <= S_DATA;
            end else begin
              state <= S_PAD;
            end
          end else begin
            cfg_idx <= cfg_idx + CFG_W'(1);
          end
        end
        S_DATA: begin
          if (hs_c) begin
            valid_o   <= 1'b1;
            cmd_o     <= tag_c;
            data_o    <= src_data_i;
            first_blk <= 1'b0;
            byte_idx  <= byte_idx + IDX_W'(1);
            if (key_phase_c) begin
              key_rem <= key_rem - KEY_W'(1);
            end else begin
              msg_rem <= msg_rem - LEN_W'(1);
            end
            // A segment ending exactly on a block boundary continues only from key into message.
            if (seg_end_c && !(blk_end_c && more_c)) begin
              src_ready_o <= 1'b0;
              state       <= blk_end_c ? S_DONE : S_PAD;
            end
          end
        end
        S_PAD: begin
          valid_o   <= 1'b1;
          cmd_o     <= tag_c;
          data_o    <= 8'h00;
          first_blk <= 1'b0;
          byte_idx  <= byte_idx + IDX_W'(1);
          if (blk_end_c) begin
            if (rem_c) begin
              src_ready_o <= 1'b1;
              state       <= S_DATA;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          done_o <= 1'b1;
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
